// File: rtl/mfe_lcd1602_pkg.sv
// Shared state encoding and display constants for the LCD1602 text sequencer.
package mfe_lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_L1,
    ST_LINE1,
    ST_CMD_L2,
    ST_LINE2,
    ST_DONE
  } state_e;

  localparam logic [7:0]  LINE1_ADDR = 8'h80;
  localparam logic [7:0]  LINE2_ADDR = 8'hC0;
  localparam int unsigned LINE_LEN   = 16;
  localparam int unsigned BUF_LEN    = 32;

  // States in which a byte is offered to the controller wrapper.
  function automatic logic is_xfer_state(input state_e s);
    return (s == ST_CMD_L1) || (s == ST_LINE1) || (s == ST_CMD_L2) || (s == ST_LINE2);
  endfunction

endpackage

// File: rtl/mfe_lcd1602_char_buf.sv
// 32 x 8 character buffer: synchronous write, asynchronous read, reset to blanks.
module mfe_lcd1602_char_buf
  import mfe_lcd1602_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [BUF_LEN];
  logic [7:0] mem_d [BUF_LEN];

  // Next buffer contents: current contents with the strobed cell replaced.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Buffer storage, cleared to the blank character on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: BLANK_CHAR};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mfe_lcd1602_text_sequencer.sv
// Streams the character buffer to an LCD1602 controller wrapper as
// line-address command followed by 16 characters, for both lines.
module mfe_lcd1602_text_sequencer
  import mfe_lcd1602_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR   = 8'h20,
  parameter bit         AUTO_REFRESH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  input  logic       ready,
  output logic [7:0] dat,
  output logic       cmd,
  output logic       vld,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LAST_L1  = 5'(LINE_LEN - 1);
  localparam logic [4:0] FIRST_L2 = 5'(LINE_LEN);
  localparam logic [4:0] LAST_L2  = 5'(BUF_LEN - 1);

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       dirty_q, dirty_d;
  logic [7:0] buf_rd_data;

  mfe_lcd1602_char_buf #(
    .BLANK_CHAR(BLANK_CHAR)
  ) u_char_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(idx_q),
    .rd_data(buf_rd_data)
  );

  // Next-state, index, dirty flag and controller-side outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dat     = '0;
    cmd     = 1'b0;
    done    = 1'b0;
    vld     = ready && is_xfer_state(state_q);
    busy    = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (refresh || (dirty_q && AUTO_REFRESH)) begin
          state_d = ST_CMD_L1;
        end
      end
      ST_CMD_L1: begin
        dat = LINE1_ADDR;
        cmd = 1'b1;
        if (ready) begin
          state_d = ST_LINE1;
          idx_d   = '0;
        end
      end
      ST_LINE1: begin
        dat = buf_rd_data;
        if (ready) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == LAST_L1) begin
            state_d = ST_CMD_L2;
          end
        end
      end
      ST_CMD_L2: begin
        dat = LINE2_ADDR;
        cmd = 1'b1;
        if (ready) begin
          state_d = ST_LINE2;
          idx_d   = FIRST_L2;
        end
      end
      ST_LINE2: begin
        dat = buf_rd_data;
        if (ready) begin
          if (idx_q == LAST_L2) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear on refresh start, but a write or request in the same cycle keeps it set.
    dirty_d = ((state_q == ST_IDLE) && (state_d == ST_CMD_L1)) ? 1'b0 : dirty_q;
    dirty_d = dirty_d | wr_en | refresh;
  end

  // State, index and dirty registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dirty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
    end
  end

endmodule

// File: tb/tb_mfe_lcd1602_text_sequencer.sv
// Self-checking bench: scoreboard of expected byte streams for an
// auto-refresh instance (A) and a manual-refresh instance (B).
module tb_mfe_lcd1602_text_sequencer;

  typedef struct packed {
    logic [7:0] dat;
    logic       cmd;
  } xfer_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp_dat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, wr_en_a, refresh_a, ready_a;
  logic [4:0] wr_addr_a;
  logic [7:0] wr_data_a, dat_a;
  logic       cmd_a, vld_a, busy_a, done_a;

  logic       rst_b, wr_en_b, refresh_b, ready_b;
  logic [4:0] wr_addr_b;
  logic [7:0] wr_data_b, dat_b;
  logic       cmd_b, vld_b, busy_b, done_b;

  mfe_lcd1602_text_sequencer #(
    .BLANK_CHAR  (8'h20),
    .AUTO_REFRESH(1'b1)
  ) dut (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .refresh(refresh_a), .ready(ready_a), .dat(dat_a), .cmd(cmd_a), .vld(vld_a),
    .busy(busy_a), .done(done_a)
  );

  mfe_lcd1602_text_sequencer #(
    .BLANK_CHAR  (8'h20),
    .AUTO_REFRESH(1'b0)
  ) dut_manual (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .refresh(refresh_b), .ready(ready_b), .dat(dat_b), .cmd(cmd_b), .vld(vld_b),
    .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  xfer_t q_a[$];
  xfer_t q_b[$];
  xfer_t e_a, e_b;
  logic [7:0] model_a [32];
  logic [7:0] model_b [32];
  int acc_a = 0, acc_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  bit chk_stable = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_dat;
  logic prev_cmd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_model_a();
    q_a.push_back('{dat: 8'h80, cmd: 1'b1});
    for (int i = 0; i < 16; i++) q_a.push_back('{dat: model_a[i], cmd: 1'b0});
    q_a.push_back('{dat: 8'hC0, cmd: 1'b1});
    for (int i = 16; i < 32; i++) q_a.push_back('{dat: model_a[i], cmd: 1'b0});
  endtask

  task automatic push_model_b();
    q_b.push_back('{dat: 8'h80, cmd: 1'b1});
    for (int i = 0; i < 16; i++) q_b.push_back('{dat: model_b[i], cmd: 1'b0});
    q_b.push_back('{dat: 8'hC0, cmd: 1'b1});
    for (int i = 16; i < 32; i++) q_b.push_back('{dat: model_b[i], cmd: 1'b0});
  endtask

  task automatic write_a(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    model_a[a] = d;
    @(posedge clk); #1;
    wr_en_a = 1'b0;
  endtask

  task automatic write_b(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d;
    model_b[a] = d;
    @(posedge clk); #1;
    wr_en_b = 1'b0;
  endtask

  task automatic wait_done_a(input int target, input int budget);
    int n = 0;
    while (done_cnt_a < target && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    checks++;
    if (done_cnt_a < target) begin
      errors++;
      $display("FAIL done_a_timeout actual=%0d required=%0d", done_cnt_a, target);
    end
  endtask

  // Monitor A: pop and compare every accepted byte; hold check while ready=0.
  initial begin
    forever begin
      @(negedge clk);
      if (done_a) begin
        done_cnt_a++;
        check("done_a_dat_zero", {dat_a, 7'd0, cmd_a}, 32'd0);
      end
      if (vld_a) begin
        acc_a++;
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_a_extra actual=%0h/%0b required=none", dat_a, cmd_a);
        end else begin
          e_a = q_a.pop_front();
          check("stream_a_dat", dat_a, e_a.dat);
          check("stream_a_cmd", cmd_a, e_a.cmd);
        end
        if (chk_stable && prev_hold) begin
          check("hold_dat", dat_a, prev_dat);
          check("hold_cmd", cmd_a, prev_cmd);
        end
      end
      prev_hold = busy_a && !done_a && !ready_a;
      prev_dat  = dat_a;
      prev_cmd  = cmd_a;
    end
  end

  // Monitor B: scoreboard for the manual-refresh instance.
  initial begin
    forever begin
      @(negedge clk);
      if (done_b) done_cnt_b++;
      if (vld_b) begin
        acc_b++;
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_b_extra actual=%0h/%0b required=none", dat_b, cmd_b);
        end else begin
          e_b = q_b.pop_front();
          check("stream_b_dat", dat_b, e_b.dat);
          check("stream_b_cmd", cmd_b, e_b.cmd);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [32];
    string s1, s2;
    int base_acc, base_done, n;

    s1 = "Make FPGA easier";
    s2 = "LCD1602 Demo 1  ";
    for (int i = 0; i < 16; i++) begin
      tv[i]      = '{addr: 5'(i),      data: s1[i], exp_dat: s1[i]};
      tv[i + 16] = '{addr: 5'(i + 16), data: s2[i], exp_dat: s2[i]};
    end
    for (int i = 0; i < 32; i++) begin
      model_a[i] = 8'h20;
      model_b[i] = 8'h20;
    end

    rst_a = 1'b1; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; refresh_a = 1'b0; ready_a = 1'b1;
    rst_b = 1'b1; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; refresh_b = 1'b0; ready_b = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", vld_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_dat", dat_a, 0);
    check("rst_cmd", cmd_a, 0);
    check("rst_busy_b", busy_b, 0);

    // Blank refresh after reset release
    push_model_a();
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    wait_done_a(1, 200);
    repeat (5) @(posedge clk); #1;
    check("blank_done_once", done_cnt_a, 1);
    check("blank_busy_after", busy_a, 0);
    check("blank_queue_empty", q_a.size(), 0);

    // Text table: writes held back by ready=0, then two identical refreshes
    ready_a = 1'b0;
    base_done = done_cnt_a;
    for (int i = 0; i < 32; i++) write_a(tv[i].addr, tv[i].data);
    for (int r = 0; r < 2; r++) begin
      q_a.push_back('{dat: 8'h80, cmd: 1'b1});
      for (int i = 0; i < 16; i++) q_a.push_back('{dat: tv[i].exp_dat, cmd: 1'b0});
      q_a.push_back('{dat: 8'hC0, cmd: 1'b1});
      for (int i = 16; i < 32; i++) q_a.push_back('{dat: tv[i].exp_dat, cmd: 1'b0});
    end
    @(posedge clk); #1;
    ready_a = 1'b1;
    wait_done_a(base_done + 2, 400);
    repeat (5) @(posedge clk); #1;
    check("text_queue_empty", q_a.size(), 0);
    check("text_busy_after", busy_a, 0);

    // ready toggling every cycle
    ready_a = 1'b0;
    chk_stable = 1'b1;
    base_done = done_cnt_a;
    base_acc = acc_a;
    write_a(5'd31, 8'h21);
    push_model_a();
    n = 0;
    while (done_cnt_a < base_done + 1 && n < 300) begin
      @(posedge clk); #1;
      ready_a = ~ready_a;
      n++;
    end
    ready_a = 1'b1;
    chk_stable = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("toggle_done", done_cnt_a, base_done + 1);
    check("toggle_count", acc_a - base_acc, 34);
    check("toggle_queue_empty", q_a.size(), 0);

    // Write behind the scan position during LINE1
    base_done = done_cnt_a;
    write_a(5'd0, 8'h4D);
    base_acc = acc_a;
    push_model_a();
    n = 0;
    while (acc_a != base_acc + 11 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("midwrite_reached_idx10", acc_a, base_acc + 11);
    wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 8'h58;
    model_a[5] = 8'h58;
    push_model_a();
    @(posedge clk); #1;
    wr_en_a = 1'b0;
    wait_done_a(base_done + 2, 300);
    repeat (5) @(posedge clk); #1;
    check("midwrite_queue_empty", q_a.size(), 0);
    check("midwrite_bytes", acc_a - base_acc, 68);

    // Reset at LINE2 index 20
    base_done = done_cnt_a;
    write_a(5'd16, 8'h4C);
    base_acc = acc_a;
    q_a.push_back('{dat: 8'h80, cmd: 1'b1});
    for (int i = 0; i < 16; i++) q_a.push_back('{dat: model_a[i], cmd: 1'b0});
    q_a.push_back('{dat: 8'hC0, cmd: 1'b1});
    for (int i = 16; i <= 20; i++) q_a.push_back('{dat: model_a[i], cmd: 1'b0});
    n = 0;
    while (acc_a != base_acc + 22 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_idx20", acc_a, base_acc + 22);
    rst_a = 1'b1;
    for (int i = 0; i < 32; i++) model_a[i] = 8'h20;
    @(posedge clk);
    @(negedge clk);
    check("abort_vld", vld_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_partial_bytes", acc_a - base_acc, 23);
    check("abort_queue_empty", q_a.size(), 0);
    push_model_a();
    @(posedge clk); #1;
    rst_a = 1'b0;
    wait_done_a(base_done + 1, 200);
    repeat (5) @(posedge clk); #1;
    check("abort_done_once", done_cnt_a, base_done + 1);
    check("abort_blank_queue_empty", q_a.size(), 0);

    // Manual-refresh instance: writes alone do not start a refresh
    write_b(5'd0, 8'h48);
    write_b(5'd1, 8'h69);
    write_b(5'd17, 8'h21);
    repeat (40) @(posedge clk); #1;
    check("manual_no_vld", acc_b, 0);
    check("manual_idle", busy_b, 0);
    push_model_b();
    refresh_b = 1'b1;
    @(posedge clk); #1;
    refresh_b = 1'b0;
    n = 0;
    while (done_cnt_b < 1 && n < 200) begin
      @(posedge clk); n++;
    end
    repeat (40) @(posedge clk); #1;
    check("manual_bytes", acc_b, 34);
    check("manual_done_once", done_cnt_b, 1);
    check("manual_queue_empty", q_b.size(), 0);
    check("manual_idle_after", busy_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
